vending_buyer: RTL

//  Customer-side initiator for the vending machine's product/currency strobe protocol.
//  - Host software loads coins into a small FIFO and requests a product.
//  - The block issues the product strobe and feeds one coin per ready window.
//  - It then collects the change stream and the give/no-change indications.
//  - It reports totals to the host.
//  - Sits between the host/testbench layer and the vending machine core.

---
 rtl/vending_buyer.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/vending_buyer.sv
// rtl/vending_buyer.sv - customer-side initiator for the vending machine strobe protocol
module vending_buyer #(
  parameter int WIDTH_OF_MONEY = 16,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                            clk,
  input  logic                            i_rst_n,
  input  logic                            i_coin_push,
  input  logic [2:0]                      i_coin_code,
  input  logic                            i_start,
  input  logic [1:0]                      i_product_sel,
  output logic                            o_fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]     o_fifo_count,
  output logic [1:0]                      o_product_code,
  output logic                            o_product_strobe,
  output logic [2:0]                      o_currency_code,
  output logic                            o_currency_strobe,
  input  logic                            i_vm_busy,
  input  logic                            i_vm_ready,
  input  logic [2:0]                      i_vm_change,
  input  logic                            i_vm_change_strobe,
  input  logic                            i_vm_no_change,
  input  logic                            i_vm_give_strobe,
  output logic                            o_busy,
  output logic                            o_stall,
  output logic                            o_done,
  output logic [WIDTH_OF_MONEY-1:0]       o_paid,
  output logic [WIDTH_OF_MONEY-1:0]       o_change_total,
  output logic                            o_no_change
);

  localparam int W  = WIDTH_OF_MONEY;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_READY,
    S_WAIT_ACK,
    S_COLLECT,
    S_FINISH
  } state_t;

  // Coin denominations shared by inserted coins and returned change
  function automatic logic [W-1:0] coin_value(input logic [2:0] code);
    logic [W-1:0] v;
    case (code)
      3'd0:    v = W'(1);
      3'd1:    v = W'(5);
      3'd2:    v = W'(10);
      3'd3:    v = W'(25);
      3'd4:    v = W'(50);
      3'd5:    v = W'(100);
      3'd6:    v = W'(200);
      default: v = W'(500);
    endcase
    return v;
  endfunction

  // Product price table
  function automatic logic [W-1:0] price_value(input logic [1:0] code);
    logic [W-1:0] v;
    case (code)
      2'd0:    v = W'(150);
      2'd1:    v = W'(300);
      2'd2:    v = W'(200);
      default: v = W'(100);
    endcase
    return v;
  endfunction

  state_t         state_q, state_d;
  logic [2:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           fifo_full_q, fifo_full_d;
  logic [W-1:0]   price_q, price_d;
  logic [1:0]     product_code_q, product_code_d;
  logic           product_strobe_q, product_strobe_d;
  logic [2:0]     currency_code_q, currency_code_d;
  logic           currency_strobe_q, currency_strobe_d;
  logic           busy_q, busy_d;
  logic           stall_q, stall_d;
  logic           done_q, done_d;
  logic [W-1:0]   paid_q, paid_d;
  logic [W-1:0]   change_total_q, change_total_d;
  logic           no_change_q, no_change_d;

  logic           push_ok;
  logic           pop;
  logic [2:0]     head;

  assign head    = mem_q[rd_ptr_q];
  // A push into a full FIFO is dropped even if a pop happens in the same cycle
  assign push_ok = i_coin_push && (count_q != DEPTH_C);

  // Purchase sequencing: next-state and next-output computation
  always_comb begin
    state_d           = state_q;
    price_d           = price_q;
    product_code_d    = product_code_q;
    product_strobe_d  = 1'b0;
    currency_code_d   = currency_code_q;
    currency_strobe_d = 1'b0;
    busy_d            = busy_q;
    stall_d           = 1'b0;
    done_d            = 1'b0;
    paid_d            = paid_q;
    change_total_d    = change_total_q;
    no_change_d       = no_change_q;
    pop               = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start && !i_vm_busy) begin
          product_code_d   = i_product_sel;
          price_d          = price_value(i_product_sel);
          paid_d           = '0;
          change_total_d   = '0;
          no_change_d      = 1'b0;
          product_strobe_d = 1'b1;
          busy_d           = 1'b1;
          state_d          = S_WAIT_READY;
        end
      end
      S_WAIT_READY: begin
        if (i_vm_ready) begin
          if (count_q != '0) begin
            pop               = 1'b1;
            currency_code_d   = head;
            currency_strobe_d = 1'b1;
            paid_d            = paid_q + coin_value(head);
            state_d           = S_WAIT_ACK;
          end else begin
            stall_d = 1'b1;
          end
        end
      end
      S_WAIT_ACK: begin
        // Hold off until the ready window closes so each window gets one coin
        if (!i_vm_ready) begin
          if (paid_q >= price_q) begin
            currency_strobe_d = 1'b1;
            state_d           = S_COLLECT;
          end else begin
            state_d = S_WAIT_READY;
          end
        end
      end
      S_COLLECT: begin
        // The machine only dispenses change while the currency strobe stays high
        currency_strobe_d = 1'b1;
        if (i_vm_change_strobe) begin
          change_total_d = change_total_q + coin_value(i_vm_change);
        end
        if (i_vm_no_change) begin
          no_change_d = 1'b1;
        end
        if (i_vm_give_strobe) begin
          currency_strobe_d = 1'b0;
          state_d           = S_FINISH;
        end
      end
      S_FINISH: begin
        if (!i_vm_busy) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Coin FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop) begin
      count_d = count_q - 1'b1;
    end
    fifo_full_d = (count_d == DEPTH_C);
  end

  // Coin storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= i_coin_code;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q           <= S_IDLE;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      fifo_full_q       <= 1'b0;
      price_q           <= '0;
      product_code_q    <= '0;
      product_strobe_q  <= 1'b0;
      currency_code_q   <= '0;
      currency_strobe_q <= 1'b0;
      busy_q            <= 1'b0;
      stall_q           <= 1'b0;
      done_q            <= 1'b0;
      paid_q            <= '0;
      change_total_q    <= '0;
      no_change_q       <= 1'b0;
    end else begin
      state_q           <= state_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      count_q           <= count_d;
      fifo_full_q       <= fifo_full_d;
      price_q           <= price_d;
      product_code_q    <= product_code_d;
      product_strobe_q  <= product_strobe_d;
      currency_code_q   <= currency_code_d;
      currency_strobe_q <= currency_strobe_d;
      busy_q            <= busy_d;
      stall_q           <= stall_d;
      done_q            <= done_d;
      paid_q            <= paid_d;
      change_total_q    <= change_total_d;
      no_change_q       <= no_change_d;
    end
  end

  assign o_fifo_full       = fifo_full_q;
  assign o_fifo_count      = count_q;
  assign o_product_code    = product_code_q;
  assign o_product_strobe  = product_strobe_q;
  assign o_currency_code   = currency_code_q;
  assign o_currency_strobe = currency_strobe_q;
  assign o_busy            = busy_q;
  assign o_stall           = stall_q;
  assign o_done            = done_q;
  assign o_paid            = paid_q;
  assign o_change_total    = change_total_q;
  assign o_no_change       = no_change_q;

endmodule
